// File: rtl/block_xfer_seq_pkg.sv
// Shared types and helpers for the LDM/STM block transfer sequencer.
package block_xfer_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_WB,
      S_DONE
   } state_e;

   localparam int WORD_BYTES = 4;

   // Addressing mode as {P,U}
   typedef enum logic [1:0] {
      AM_DA = 2'b00,
      AM_IA = 2'b01,
      AM_DB = 2'b10,
      AM_IB = 2'b11
   } am_e;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/block_xfer_seq_prio_enc16.sv
// Lowest-set-bit encoder over a 16-bit register list.
module prio_enc16 (
   input  logic [15:0] i_vec,
   output logic [3:0]  o_index,
   output logic        o_valid
);

   always_comb begin
      o_index = '0;
      for (int i = 15; i >= 0; i--) begin
         if (i_vec[i]) o_index = 4'(i);
      end
   end

   assign o_valid = |i_vec;

endmodule

// File: rtl/block_xfer_seq.sv
// LDM/STM sequencer: walks the register list one word beat at a time,
// stalls the pipeline while busy, then optionally writes back the base.
import block_xfer_seq_pkg::*;

module block_xfer_seq #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [15:0]       i_reg_list,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_p_flag,
   input  logic              i_u_flag,
   input  logic              i_w_flag,
   input  logic              i_l_flag,
   input  logic              i_s_flag,
   input  logic [3:0]        i_base_idx,
   input  logic [ADDR_W-1:0] i_rf_rdata,
   input  logic [ADDR_W-1:0] i_mem_rdata,
   input  logic              i_mem_ready,
   output logic              o_stall,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [ADDR_W-1:0] o_mem_wdata,
   output logic [3:0]        o_reg_idx,
   output logic              o_reg_we,
   output logic [ADDR_W-1:0] o_reg_wdata,
   output logic              o_user_bank,
   output logic              o_wb_en,
   output logic [ADDR_W-1:0] o_wb_value,
   output logic              o_done
);

   state_e            r_state;
   logic [15:0]       r_list;
   logic [ADDR_W-1:0] r_base;
   logic              r_p, r_u, r_w, r_l;
   logic              r_wb_supp;
   logic [4:0]        r_n;

   logic [15:0]       w_next_list;
   logic [15:0]       w_enc_in;
   logic [3:0]        w_enc_idx;
   logic              w_enc_vld;
   logic [4:0]        w_n;
   logic [ADDR_W-1:0] w_step, w_off, w_woff, w_base_al, w_start_addr;
   am_e               w_am;

   // In XFER the encoder looks ahead at the list with the current beat removed
   assign w_next_list = r_list & ~(16'h0001 << o_reg_idx);
   assign w_enc_in    = (r_state == S_XFER) ? w_next_list : r_list;

   prio_enc16 u_enc (
      .i_vec   (w_enc_in),
      .o_index (w_enc_idx),
      .o_valid (w_enc_vld)
   );

   assign w_n       = popcount16(r_list);
   assign w_step    = ADDR_W'(WORD_BYTES);
   assign w_off     = ADDR_W'(w_n) * w_step;
   assign w_woff    = ADDR_W'(r_n) * w_step;
   assign w_base_al = {r_base[ADDR_W-1:2], 2'b00};
   assign w_am      = am_e'({r_p, r_u});

   always_comb begin
      case (w_am)
         AM_IA:   w_start_addr = w_base_al;
         AM_IB:   w_start_addr = w_base_al + w_step;
         AM_DA:   w_start_addr = w_base_al - w_off + w_step;
         default: w_start_addr = w_base_al - w_off;
      endcase
   end

   // Load strobe must coincide with the completing beat, so it is not registered
   assign o_reg_we    = (r_state == S_XFER) & r_l & i_mem_ready;
   assign o_reg_wdata = o_reg_we ? i_mem_rdata : '0;
   assign o_mem_wdata = (o_mem_req & o_mem_we) ? i_rf_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_list      <= '0;
         r_base      <= '0;
         r_p         <= 1'b0;
         r_u         <= 1'b0;
         r_w         <= 1'b0;
         r_l         <= 1'b0;
         r_wb_supp   <= 1'b0;
         r_n         <= '0;
         o_stall     <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_reg_idx   <= '0;
         o_user_bank <= 1'b0;
         o_wb_en     <= 1'b0;
         o_wb_value  <= '0;
         o_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_list      <= i_reg_list;
                  r_base      <= i_base_addr;
                  r_p         <= i_p_flag;
                  r_u         <= i_u_flag;
                  r_w         <= i_w_flag;
                  r_l         <= i_l_flag;
                  r_wb_supp   <= i_l_flag & i_reg_list[i_base_idx];
                  o_stall     <= 1'b1;
                  o_user_bank <= i_s_flag;
                  r_state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_n <= w_n;
               if (!w_enc_vld) begin
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  o_mem_req  <= 1'b1;
                  o_mem_we   <= ~r_l;
                  o_mem_addr <= w_start_addr;
                  o_reg_idx  <= w_enc_idx;
                  r_state    <= S_XFER;
               end
            end
            S_XFER: begin
               if (i_mem_ready) begin
                  r_list <= w_next_list;
                  if (w_enc_vld) begin
                     o_mem_addr <= o_mem_addr + w_step;
                     o_reg_idx  <= w_enc_idx;
                  end else begin
                     o_mem_req  <= 1'b0;
                     o_mem_we   <= 1'b0;
                     o_mem_addr <= '0;
                     o_reg_idx  <= '0;
                     if (r_w) begin
                        o_wb_en    <= ~r_wb_supp;
                        o_wb_value <= r_u ? r_base + w_woff : r_base - w_woff;
                        r_state    <= S_WB;
                     end else begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end
               end
            end
            S_WB: begin
               o_wb_en    <= 1'b0;
               o_wb_value <= '0;
               o_done     <= 1'b1;
               r_state    <= S_DONE;
            end
            S_DONE: begin
               o_done      <= 1'b0;
               o_stall     <= 1'b0;
               o_user_bank <= 1'b0;
               r_list      <= '0;
               r_base      <= '0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Directed bench for block_xfer_seq with a transaction-level reference model.
module tb_block_xfer_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start;
   logic [15:0] i_reg_list;
   logic [31:0] i_base_addr;
   logic        i_p_flag, i_u_flag, i_w_flag, i_l_flag, i_s_flag;
   logic [3:0]  i_base_idx;
   logic [31:0] i_rf_rdata, i_mem_rdata;
   logic        i_mem_ready;
   logic        o_stall, o_mem_req, o_mem_we, o_reg_we, o_user_bank, o_wb_en, o_done;
   logic [31:0] o_mem_addr, o_mem_wdata, o_reg_wdata, o_wb_value;
   logic [3:0]  o_reg_idx;

   block_xfer_seq #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_reg_list(i_reg_list),
      .i_base_addr(i_base_addr), .i_p_flag(i_p_flag), .i_u_flag(i_u_flag),
      .i_w_flag(i_w_flag), .i_l_flag(i_l_flag), .i_s_flag(i_s_flag),
      .i_base_idx(i_base_idx), .i_rf_rdata(i_rf_rdata), .i_mem_rdata(i_mem_rdata),
      .i_mem_ready(i_mem_ready), .o_stall(o_stall), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_reg_idx(o_reg_idx), .o_reg_we(o_reg_we), .o_reg_wdata(o_reg_wdata),
      .o_user_bank(o_user_bank), .o_wb_en(o_wb_en), .o_wb_value(o_wb_value),
      .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Register file and memory contents are simple functions of index/address
   assign i_rf_rdata  = 32'hC0DE_0000 | 32'(o_reg_idx);
   assign i_mem_rdata = o_mem_addr ^ 32'h5A5A_0000;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: expected beats, writeback and latency of one instruction
   logic [31:0] m_addr[$];
   logic [3:0]  m_idx[$];
   bit          m_l, m_s, m_wb;
   logic [31:0] m_wbv;
   int          m_len;
   int          t_start = 0;
   bit          chk_on = 1'b0;

   logic [31:0] obs_addr[$];
   logic [31:0] obs_wbv;
   int          done_rel, n_req, n_wb, n_we, n_stall;

   int rel;
   bit exp_stall, exp_beat;
   always @(negedge clk) begin
      if (chk_on) begin
         rel       = cyc - t_start;
         exp_stall = (rel >= 1) && (rel <= m_len);
         exp_beat  = (rel >= 2) && (m_addr.size() > 0);
         chk("stall",     32'(o_stall),     32'(exp_stall));
         chk("done",      32'(o_done),      32'(rel == m_len));
         chk("user_bank", 32'(o_user_bank), 32'(exp_stall && m_s));
         chk("mem_req",   32'(o_mem_req),   32'(exp_beat));
         chk("reg_we",    32'(o_reg_we),    32'(exp_beat && m_l && i_mem_ready));
         chk("wb_en",     32'(o_wb_en),     32'(m_wb && rel == m_len - 1));
         if (o_wb_en) begin
            chk("wb_value", o_wb_value, m_wbv);
            obs_wbv = o_wb_value;
         end
         if (exp_beat) begin
            chk("mem_addr",  o_mem_addr,        m_addr[0]);
            chk("reg_idx",   32'(o_reg_idx),    32'(m_idx[0]));
            chk("mem_we",    32'(o_mem_we),     32'(!m_l));
            chk("mem_wdata", o_mem_wdata,       m_l ? 32'h0 : (32'hC0DE_0000 | 32'(m_idx[0])));
            chk("reg_wdata", o_reg_wdata,       (m_l && i_mem_ready) ? (m_addr[0] ^ 32'h5A5A_0000) : 32'h0);
            if (i_mem_ready) begin
               obs_addr.push_back(o_mem_addr);
               void'(m_addr.pop_front());
               void'(m_idx.pop_front());
            end
         end
         if (o_done)    done_rel = rel;
         if (o_mem_req) n_req++;
         if (o_wb_en)   n_wb++;
         if (o_reg_we)  n_we++;
         if (o_stall)   n_stall++;
      end
   end

   task automatic run(input logic [15:0] list, input logic [31:0] base,
                      input bit p, input bit u, input bit w, input bit l, input bit s,
                      input logic [3:0] bidx, input int waits);
      int n = 0;
      int wl = waits;
      logic [31:0] a;
      m_addr.delete(); m_idx.delete(); obs_addr.delete();
      for (int k = 0; k < 16; k++) if (list[k]) n++;
      a = {base[31:2], 2'b00};
      if (p && u)        a = a + 32'd4;
      else if (!p && !u) a = a - 32'(4 * n) + 32'd4;
      else if (p && !u)  a = a - 32'(4 * n);
      for (int k = 0; k < 16; k++) begin
         if (list[k]) begin
            m_idx.push_back(4'(k));
            m_addr.push_back(a);
            a = a + 32'd4;
         end
      end
      m_l   = l;
      m_s   = s;
      m_wb  = (n != 0) && w && !(l && list[bidx]);
      m_wbv = u ? base + 32'(4 * n) : base - 32'(4 * n);
      m_len = (n == 0) ? 2 : 2 + n + (w ? 1 : 0) + waits;
      obs_wbv = 32'h0; done_rel = -1; n_req = 0; n_wb = 0; n_we = 0; n_stall = 0;
      i_reg_list = list; i_base_addr = base; i_base_idx = bidx;
      i_p_flag = p; i_u_flag = u; i_w_flag = w; i_l_flag = l; i_s_flag = s;
      i_mem_ready = 1'b1;
      i_start = 1'b1;
      t_start = cyc;
      chk_on  = 1'b1;
      @(posedge clk); #1;
      // Inputs are latched at start; scramble them to prove it
      i_start = 1'b0; i_reg_list = 16'hFFFF; i_base_addr = 32'hDEAD_BEEF;
      i_p_flag = ~p; i_u_flag = ~u; i_w_flag = ~w; i_l_flag = ~l; i_s_flag = ~s;
      for (int c = 0; c < m_len + 3; c++) begin
         i_start = (c == 1) && (m_len > 3);
         if (o_mem_req && wl > 0) begin
            i_mem_ready = 1'b0;
            wl--;
         end else begin
            i_mem_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      i_start = 1'b0;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_stall"},     32'(o_stall),     32'h0);
      chk({pfx, "_mem_req"},   32'(o_mem_req),   32'h0);
      chk({pfx, "_mem_we"},    32'(o_mem_we),    32'h0);
      chk({pfx, "_mem_addr"},  o_mem_addr,       32'h0);
      chk({pfx, "_mem_wdata"}, o_mem_wdata,      32'h0);
      chk({pfx, "_reg_idx"},   32'(o_reg_idx),   32'h0);
      chk({pfx, "_reg_we"},    32'(o_reg_we),    32'h0);
      chk({pfx, "_reg_wdata"}, o_reg_wdata,      32'h0);
      chk({pfx, "_user_bank"}, 32'(o_user_bank), 32'h0);
      chk({pfx, "_wb_en"},     32'(o_wb_en),     32'h0);
      chk({pfx, "_wb_value"},  o_wb_value,       32'h0);
      chk({pfx, "_done"},      32'(o_done),      32'h0);
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_reg_list = '0; i_base_addr = '0;
      i_p_flag = 0; i_u_flag = 0; i_w_flag = 0; i_l_flag = 0; i_s_flag = 0;
      i_base_idx = '0; i_mem_ready = 1'b1;
      #22;
      chk_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // STMIA R0-R3, base 0x1000, writeback
      run(16'h000F, 32'h0000_1000, 0, 1, 1, 0, 0, 4'd13, 0);
      chk("t1_done_rel", 32'(done_rel), 32'd7);
      chk("t1_beats",    32'(obs_addr.size()), 32'd4);
      chk("t1_addr0",    obs_addr[0], 32'h0000_1000);
      chk("t1_addr3",    obs_addr[3], 32'h0000_100C);
      chk("t1_wb",       obs_wbv, 32'h0000_1010);
      chk("t1_n_wb",     32'(n_wb), 32'd1);

      // LDMDB R0,R15, base 0x2000, no writeback
      run(16'h8001, 32'h0000_2000, 1, 0, 0, 1, 0, 4'd13, 0);
      chk("t2_addr0", obs_addr[0], 32'h0000_1FF8);
      chk("t2_addr1", obs_addr[1], 32'h0000_1FFC);
      chk("t2_n_we",  32'(n_we), 32'd2);
      chk("t2_n_wb",  32'(n_wb), 32'd0);

      // LDMIA with base in list: writeback suppressed
      run(16'h0004, 32'h0000_4000, 0, 1, 1, 1, 0, 4'd2, 0);
      chk("t3_n_we",     32'(n_we), 32'd1);
      chk("t3_n_wb",     32'(n_wb), 32'd0);
      chk("t3_done_rel", 32'(done_rel), 32'd4);

      // Empty list
      run(16'h0000, 32'h0000_5000, 0, 1, 1, 0, 0, 4'd0, 0);
      chk("t4_done_rel", 32'(done_rel), 32'd2);
      chk("t4_n_stall",  32'(n_stall), 32'd2);
      chk("t4_n_req",    32'(n_req), 32'd0);
      chk("t4_n_wb",     32'(n_wb), 32'd0);

      // STMIB with 3 wait cycles on the first beat, user bank
      run(16'h0003, 32'h0000_1000, 1, 1, 0, 0, 1, 4'd13, 3);
      chk("t5_addr0",    obs_addr[0], 32'h0000_1004);
      chk("t5_done_rel", 32'(done_rel), 32'd7);
      chk("t5_n_req",    32'(n_req), 32'd5);

      // STMDA across address zero, writeback wraps
      run(16'h0110, 32'h0000_0004, 0, 0, 1, 0, 0, 4'd13, 0);
      chk("t6_addr0", obs_addr[0], 32'h0000_0000);
      chk("t6_addr1", obs_addr[1], 32'h0000_0004);
      chk("t6_wb",    obs_wbv, 32'hFFFF_FFFC);

      // Reset during the second beat of a 4-beat LDMIA
      chk_on = 1'b0;
      i_reg_list = 16'h000F; i_base_addr = 32'h0000_3000; i_base_idx = 4'd13;
      i_p_flag = 0; i_u_flag = 1; i_w_flag = 1; i_l_flag = 1; i_s_flag = 1;
      i_mem_ready = 1'b1; i_start = 1'b1;
      @(posedge clk); #1; i_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pre_addr", o_mem_addr, 32'h0000_3004);
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Same STMIA again runs cleanly after the abort
      run(16'h000F, 32'h0000_1000, 0, 1, 1, 0, 0, 4'd13, 0);
      chk("t7_done_rel", 32'(done_rel), 32'd7);
      chk("t7_wb",       obs_wbv, 32'h0000_1010);

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
